// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit: owns HI/LO, sequences fixed-latency mult/div
// operations and requests a D-stage stall while an MDU result is outstanding.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        E_start,
    input  logic [2:0]  E_mdu_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_hilo_sel,
    input  logic        D_is_mdu,
    output logic [31:0] E_mdu_out,
    output logic        E_busy,
    output logic        D_mdu_stall,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DW         = 32;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [DW-1:0]    r_pend_hi;
    logic [DW-1:0]    r_pend_lo;
    logic             r_pend_we;
    logic [DW-1:0]    r_hi;
    logic [DW-1:0]    r_lo;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [DW-1:0]    w_pend_hi_nxt;
    logic [DW-1:0]    w_pend_lo_nxt;
    logic             w_pend_we_nxt;
    logic [DW-1:0]    w_hi_nxt;
    logic [DW-1:0]    w_lo_nxt;

    logic             w_op_long;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic             w_div_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [DW-1:0]    w_num;
    logic [DW-1:0]    w_den;
    logic [DW-1:0]    w_den_safe;
    logic [DW-1:0]    w_q_mag;
    logic [DW-1:0]    w_r_mag;
    logic [DW-1:0]    w_quot;
    logic [DW-1:0]    w_rem;

    assign w_op_long = (E_mdu_op == OP_MULT) || (E_mdu_op == OP_MULTU) ||
                       (E_mdu_op == OP_DIV)  || (E_mdu_op == OP_DIVU);

    // Products: sign- or zero-extend operands to 64 bits before multiplying.
    assign w_prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};

    // Signed division runs on magnitudes so 0x80000000 / -1 needs no special case.
    assign w_div_signed = (E_mdu_op == OP_DIV);
    assign w_a_neg      = w_div_signed & E_A[31];
    assign w_b_neg      = w_div_signed & E_B[31];
    assign w_num        = w_a_neg ? (~E_A + 32'd1) : E_A;
    assign w_den        = w_b_neg ? (~E_B + 32'd1) : E_B;
    assign w_den_safe   = (w_den == 32'd0) ? 32'd1 : w_den;
    assign w_q_mag      = w_num / w_den_safe;
    assign w_r_mag      = w_num % w_den_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Sequencer next-state: accept commands only in IDLE, commit on the last busy edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_we_nxt = r_pend_we;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;

        case (r_state)
            S_IDLE: begin
                if (E_start) begin
                    case (E_mdu_op)
                        OP_MULT: begin
                            w_pend_hi_nxt = w_prod_s[63:32];
                            w_pend_lo_nxt = w_prod_s[31:0];
                            w_pend_we_nxt = 1'b1;
                            w_count_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt   = S_BUSY;
                        end
                        OP_MULTU: begin
                            w_pend_hi_nxt = w_prod_u[63:32];
                            w_pend_lo_nxt = w_prod_u[31:0];
                            w_pend_we_nxt = 1'b1;
                            w_count_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt   = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_pend_hi_nxt = w_rem;
                            w_pend_lo_nxt = w_quot;
                            w_pend_we_nxt = (E_B != 32'd0);
                            w_count_nxt   = CNT_W'(DIV_CYCLES);
                            w_state_nxt   = S_BUSY;
                        end
                        OP_MTHI: w_hi_nxt = E_A;
                        OP_MTLO: w_lo_nxt = E_A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                w_count_nxt = r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    if (r_pend_we) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_we <= w_pend_we_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    assign E_busy      = (r_state == S_BUSY);
    assign HI_q        = r_hi;
    assign LO_q        = r_lo;
    assign E_mdu_out   = E_hilo_sel ? r_hi : r_lo;
    assign D_mdu_stall = D_is_mdu & (E_busy | (E_start & w_op_long));

endmodule
